// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared SVM constants and feature packer state encoding
package svm_pkg;

    localparam int SVM_NBITS   = 9;
    localparam int SVM_F_WIDTH = 214;

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        SEND_V = 2'b01,
        SEND_A = 2'b11
    } packer_state_t;

endpackage

// File: rtl/svm_feature_packer_if.sv
// rtl/svm_feature_packer_if.sv - feature input stream, packed vector output and status
interface svm_feature_packer_if
    import svm_pkg::*;
#(
    parameter int NBITS   = SVM_NBITS,
    parameter int IN_BITS = 16,
    parameter int F_WIDTH = SVM_F_WIDTH
);

    logic signed [IN_BITS-1:0]   s_feature;
    logic                        s_valid;
    logic                        s_last;
    logic                        s_ready;
    logic [NBITS*F_WIDTH-1:0]    out_features;
    logic                        fout_valid;
    logic                        fout_ready;
    logic                        frame_err;
    logic [15:0]                 frame_cnt;

    modport master (
        output s_feature, s_valid, s_last, fout_ready,
        input  s_ready, out_features, fout_valid, frame_err, frame_cnt
    );

    modport slave (
        input  s_feature, s_valid, s_last, fout_ready,
        output s_ready, out_features, fout_valid, frame_err, frame_cnt
    );

endinterface

// File: rtl/feature_quantize.sv
// rtl/feature_quantize.sv - arithmetic shift then clamp (SVM_FEATURE_SAT_EN) or wrap to NBITS
module feature_quantize
    import svm_pkg::*;
#(
    parameter int IN_BITS = 16,
    parameter int NBITS   = SVM_NBITS,
    parameter int SHIFT   = 4
) (
    input  logic signed [IN_BITS-1:0] feature,
    output logic signed [NBITS-1:0]   q
);

`ifdef SVM_FEATURE_SAT_EN
    localparam logic signed [IN_BITS-1:0] Q_MAX = IN_BITS'((1 << (NBITS-1)) - 1);
    localparam logic signed [IN_BITS-1:0] Q_MIN = IN_BITS'(-(1 << (NBITS-1)));

    logic signed [IN_BITS-1:0] shifted;

    assign shifted = feature >>> SHIFT;

    always_comb begin
        q = NBITS'(shifted);
        if (shifted > Q_MAX) begin
            q = NBITS'(Q_MAX);
        end else if (shifted < Q_MIN) begin
            q = NBITS'(Q_MIN);
        end
    end
`else
    assign q = NBITS'(feature >>> SHIFT);
`endif

endmodule

// File: rtl/svm_feature_packer.sv
// rtl/svm_feature_packer.sv - packs F_WIDTH quantized features, presents each vector twice (SVM_FEATURE_SAT_EN selects clamping)
module svm_feature_packer
    import svm_pkg::*;
#(
    parameter int NBITS       = SVM_NBITS,
    parameter int IN_BITS     = 16,
    parameter int SHIFT       = 4,
    parameter int F_WIDTH     = SVM_F_WIDTH,
    parameter int LOG_F_WIDTH = $clog2(F_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    svm_feature_packer_if.slave  bus
);

    localparam logic [LOG_F_WIDTH-1:0] LAST_IDX = LOG_F_WIDTH'(F_WIDTH - 1);

    packer_state_t            state;
    logic [LOG_F_WIDTH-1:0]   index;
    logic                     s_ready_r;
    logic                     fout_valid_r;
    logic                     frame_err_r;
    logic [15:0]              frame_cnt_r;
    logic [NBITS*F_WIDTH-1:0] features_r;
    logic signed [NBITS-1:0]  q;

    feature_quantize #(
        .IN_BITS (IN_BITS),
        .NBITS   (NBITS),
        .SHIFT   (SHIFT)
    ) u_quantize (
        .feature (bus.s_feature),
        .q       (q)
    );

    assign bus.s_ready      = s_ready_r;
    assign bus.fout_valid   = fout_valid_r;
    assign bus.out_features = features_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.frame_cnt    = frame_cnt_r;

    // The vector is zeroed as the second presentation retires, so a frame
    // cut short by an early s_last leaves its unwritten slots at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            index        <= '0;
            s_ready_r    <= 1'b1;
            fout_valid_r <= 1'b0;
            features_r   <= '0;
            frame_err_r  <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.s_valid) begin
                        features_r[index*NBITS +: NBITS] <= q;
                        if ((index == LAST_IDX) || bus.s_last) begin
                            if ((index != LAST_IDX) || !bus.s_last) begin
                                frame_err_r <= 1'b1;
                            end
                            index        <= '0;
                            state        <= SEND_V;
                            s_ready_r    <= 1'b0;
                            fout_valid_r <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                SEND_V: begin
                    if (bus.fout_ready) begin
                        state <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (bus.fout_ready) begin
                        state        <= FILL;
                        frame_cnt_r  <= frame_cnt_r + 1'b1;
                        fout_valid_r <= 1'b0;
                        s_ready_r    <= 1'b1;
                        features_r   <= '0;
                    end
                end
                default: begin
                    state        <= FILL;
                    index        <= '0;
                    s_ready_r    <= 1'b1;
                    fout_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/svm_feature_packer.md
# svm_feature_packer

Upstream feeder for the SVM classifier. Accepts one raw signed feature per cycle from the feature-extraction stage, rescales it to NBITS, and packs F_WIDTH of them into a wide feature vector. The vector is then presented twice on a valid/ready port: once for the valence pass and once for the arousal pass, matching the SVM's two-request sequence. The next frame is not accepted until both presentations complete.

## Interface
- NBITS, 9, quantized feature width; must match the SVM's NBITS
- IN_BITS, 16, raw input feature width; must be ≥ NBITS
- SHIFT, 4, arithmetic right shift applied before narrowing; range 0..IN_BITS-NBITS
- F_WIDTH, 214, features per frame
- LOG_F_WIDTH, `ceilLog2(F_WIDTH)`, counter width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- s_feature  input  IN_BITS  signed raw feature
- s_valid  input  1  s_feature valid
- s_last  input  1  marks the final feature of a frame
- s_ready  output  1  packer can accept a feature
- out_features  output  NBITS*F_WIDTH  packed vector; feature k is at bits [k*NBITS +: NBITS]
- fout_valid  output  1  out_features valid; connects to the SVM's fin_valid
- fout_ready  input  1  connects to the SVM's fin_ready
- frame_err  output  1  sticky flag for s_last/count mismatch; cleared only by rst
- frame_cnt  output  16  completed frames, where a frame counts once both presentations have fired; wraps at 2^16

## Operation
- States: FILL, SEND_V, SEND_A.
- Reset values:
  - state = FILL, index = 0
  - s_ready = 1, fout_valid = 0
  - out_features = 0, frame_err = 0, frame_cnt = 0
- s_ready = (state == FILL). An input is accepted when s_valid && s_ready.

FILL
- Each accepted feature is quantized and written to slot index, then index increments.
- If an accepted beat has index == F_WIDTH-1 and s_last is high, the frame is complete: go to SEND_V, clear index.
- Early s_last (index < F_WIDTH-1): set frame_err. Unwritten slots are set to 0 and the frame goes to SEND_V.
- Missing s_last at index == F_WIDTH-1: set frame_err. The frame still goes to SEND_V; subsequent beats belong to the next frame.

SEND_V
- fout_valid = 1.
- On fout_valid && fout_ready, go to SEND_A. fout_valid stays high and out_features is unchanged.

SEND_A
- fout_valid = 1.
- On fire, go to FILL, increment frame_cnt, and drop fout_valid.

General rules
- out_features is held constant whenever fout_valid is high.
- Slots are written only in FILL.

Quantization
- q = s_feature >>> SHIFT (arithmetic shift).
- The result is narrowed to NBITS according to the Configuration section.

## Timing
- Input acceptance: one feature per cycle at full throughput.
- Latency: the last feature accepted in cycle t gives fout_valid = 1 in cycle t+1.
- Best-case frame period: F_WIDTH + 2 cycles, when fout_ready is held high.
- The SVM holds fin_ready low while it computes. The packer simply waits; there is no timeout.
- s_ready is low in SEND_V and SEND_A. Upstream must hold its data until s_ready returns.
- s_ready returns the cycle after the SEND_A fire.
- Reset mid-frame: partial data is discarded. All outputs return to their reset values immediately, without waiting for a clock edge.
- fout_ready is ignored while fout_valid is low.

## Configuration
- Macro: SVM_FEATURE_SAT_EN.
- Defined: q is clamped to [-2^(NBITS-1), 2^(NBITS-1)-1].
- Undefined: q is truncated to its low NBITS bits (two's-complement wrap).
- All other behaviour is identical in both builds.

## Structure
- Shared package svm_pkg holds:
  - the state enum: FILL = 2'b00, SEND_V = 2'b01, SEND_A = 2'b11
  - the default constants SVM_NBITS and SVM_F_WIDTH, used by this block and the SVM alike
- Sub-module feature_quantize: purely combinational shift plus clamp-or-wrap, parameterized by IN_BITS, NBITS and SHIFT. It carries the SVM_FEATURE_SAT_EN conditional.
- The packer holds the FSM, the index counter, the vector register and the flags.

## Test plan
All scenarios use the default parameters, except scenario 4 (F_WIDTH = 4).

1. Nominal frame:
   - Stimulus: send features 0..213 with raw value 16*k; assert s_last on k = 213; hold fout_ready high.
   - Response: fout_valid rises one cycle after the last beat. Slot k = k wrapped to 9 bits without the macro, and clamped at 255 with it. Exactly two fires occur; then frame_cnt = 1 and s_ready = 1.
2. Saturation:
   - Stimulus: raw values +32767 and -32768.
   - Response: with SVM_FEATURE_SAT_EN, slots = 255 and -256. Without it, slots = 0x1FF and 0x000.
3. Backpressure:
   - Stimulus: hold fout_ready low for 500 cycles after the frame completes, then pulse it twice.
   - Response: fout_valid stays high and out_features is stable throughout. s_ready is low until the cycle after the second fire.
4. Early s_last (F_WIDTH = 4):
   - Stimulus: s_last on the 2nd beat.
   - Response: frame_err = 1; slots 2..3 = 0; the frame is presented twice.
5. Async reset:
   - Stimulus: assert rst mid-FILL at index 100, between clock edges.
   - Response: outputs reach their reset values before the next clk edge. A fresh full frame afterwards packs correctly and frame_err = 0.
